// File: rtl/rv32_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters for the 5-stage RV32 pipeline.
// Fetch gets a zero-latency next-PC guess; Execute trains the table and flags mispredicts.
module rv32_branch_predictor #(
  parameter int word_width   = 32,
  parameter int entries      = 16,
  parameter int counter_bits = 2,
  parameter int stat_width   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [word_width-1:0] PCF,
  output logic                  PredTakenF,
  output logic [word_width-1:0] PredPCF,
  input  logic                  UpdateE,
  input  logic [word_width-1:0] PCE,
  input  logic                  TakenE,
  input  logic [word_width-1:0] TargetE,
  input  logic                  PredTakenE,
  input  logic [word_width-1:0] PredPCE,
  output logic                  MispredictE,
  output logic [word_width-1:0] RedirectPCE,
  input  logic                  Invalidate,
  output logic [stat_width-1:0] BranchCount,
  output logic [stat_width-1:0] MispredictCount
);

  localparam int idx_bits = $clog2(entries);
  localparam int tag_bits = word_width - idx_bits - 2;
  localparam logic [counter_bits-1:0] CTR_MAX = '1;
  localparam logic [counter_bits-1:0] CTR_WT  = counter_bits'(1 << (counter_bits - 1));
  localparam logic [counter_bits-1:0] CTR_WNT = counter_bits'((1 << (counter_bits - 1)) - 1);

  logic [entries-1:0]      r_valid;
  logic [tag_bits-1:0]     r_tag     [entries];
  logic [word_width-1:0]   r_target  [entries];
  logic [counter_bits-1:0] r_counter [entries];
  logic [stat_width-1:0]   r_branchCount;
  logic [stat_width-1:0]   r_mispredictCount;

  logic [idx_bits-1:0]     w_idxF;
  logic [tag_bits-1:0]     w_tagF;
  logic                    w_hitF;
  logic [idx_bits-1:0]     w_idxE;
  logic [tag_bits-1:0]     w_tagE;
  logic                    w_hitE;
  logic [counter_bits-1:0] w_ctrE;
  logic [counter_bits-1:0] w_ctrNext;
  logic                    w_unusedPcBits;

  // Instructions are word aligned, so the low PC bits never select anything.
  assign w_unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  assign w_idxF     = PCF[idx_bits+1:2];
  assign w_tagF     = PCF[word_width-1:idx_bits+2];
  assign w_hitF     = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
  assign PredTakenF = w_hitF && r_counter[w_idxF][counter_bits-1];
  assign PredPCF    = PredTakenF ? r_target[w_idxF] : PCF + word_width'(4);

  assign w_idxE = PCE[idx_bits+1:2];
  assign w_tagE = PCE[word_width-1:idx_bits+2];
  assign w_hitE = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);

  assign MispredictE = UpdateE && ((TakenE != PredTakenE) || (TakenE && (PredPCE != TargetE)));
  assign RedirectPCE = TakenE ? TargetE : PCE + word_width'(4);

  always_comb begin
    w_ctrE    = r_counter[w_idxE];
    w_ctrNext = w_ctrE;
    if (TakenE) begin
      if (w_ctrE != CTR_MAX) w_ctrNext = w_ctrE + counter_bits'(1);
    end else if (w_ctrE != '0) begin
      w_ctrNext = w_ctrE - counter_bits'(1);
    end
  end

  // Invalidate wins over a same-cycle update so fence.i never leaves a fresh entry behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < entries; i++) begin
        r_tag[i]     <= '0;
        r_target[i]  <= '0;
        r_counter[i] <= CTR_WNT;
      end
    end else if (Invalidate) begin
      r_valid <= '0;
    end else if (UpdateE) begin
      if (w_hitE) begin
        r_counter[w_idxE] <= w_ctrNext;
        if (TakenE) r_target[w_idxE] <= TargetE;
      end else if (TakenE) begin
        r_valid[w_idxE]   <= 1'b1;
        r_tag[w_idxE]     <= w_tagE;
        r_target[w_idxE]  <= TargetE;
        r_counter[w_idxE] <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else begin
      if (UpdateE && (r_branchCount != '1))
        r_branchCount <= r_branchCount + stat_width'(1);
      if (MispredictE && (r_mispredictCount != '1))
        r_mispredictCount <= r_mispredictCount + stat_width'(1);
    end
  end

  assign BranchCount     = r_branchCount;
  assign MispredictCount = r_mispredictCount;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Bench for rv32_branch_predictor: directed scenarios followed by random traffic,
// all compared against an arithmetic model of the BTB (4-bit stats to reach saturation).
module tb_rv32_branch_predictor;

  localparam int ENT    = 16;
  localparam int CTRMAX = 3;
  localparam int SATMAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredPCF;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] TargetE;
  logic        PredTakenE;
  logic [31:0] PredPCE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic        Invalidate;
  logic [3:0]  BranchCount;
  logic [3:0]  MispredictCount;

  always #5 clk = ~clk;

  rv32_branch_predictor #(
    .word_width(32), .entries(ENT), .counter_bits(2), .stat_width(4)
  ) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
    .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredPCE(PredPCE), .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE), .Invalidate(Invalidate),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  bit          mValid  [ENT];
  logic [31:0] mTag    [ENT];
  logic [31:0] mTarget [ENT];
  int          mCtr    [ENT];
  int          mBranch;
  int          mMiss;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit mHit(input logic [31:0] pc);
    return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
  endfunction

  function automatic bit mPredTaken(input logic [31:0] pc);
    return mHit(pc) && (mCtr[idxOf(pc)] >= (CTRMAX + 1) / 2);
  endfunction

  function automatic logic [31:0] mPredPc(input logic [31:0] pc);
    return mPredTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] randPc();
    return (($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 2));
  endfunction

  task automatic mReset();
    for (int i = 0; i < ENT; i++) begin
      mValid[i]  = 1'b0;
      mTag[i]    = '0;
      mTarget[i] = '0;
      mCtr[i]    = 1;
    end
    mBranch = 0;
    mMiss   = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Execute/Fetch cycle: check combinational outputs, clock, then advance model and check stats.
  task automatic applyStimulus(input bit upd, input logic [31:0] pce, input bit tk,
                               input logic [31:0] tgt, input bit pt, input logic [31:0] ppc,
                               input bit inv, input logic [31:0] pcf);
    bit expMis;
    int i;
    UpdateE = upd; PCE = pce; TakenE = tk; TargetE = tgt;
    PredTakenE = pt; PredPCE = ppc; Invalidate = inv; PCF = pcf;
    #1;
    expMis = upd && ((tk != pt) || (tk && (ppc != tgt)));
    checkOutput("pred_taken", {31'd0, PredTakenF}, {31'd0, mPredTaken(pcf)});
    checkOutput("pred_pc", PredPCF, mPredPc(pcf));
    checkOutput("mispredict", {31'd0, MispredictE}, {31'd0, expMis});
    checkOutput("redirect_pc", RedirectPCE, tk ? tgt : pce + 32'd4);
    @(posedge clk);
    i = idxOf(pce);
    if (inv) begin
      for (int k = 0; k < ENT; k++) mValid[k] = 1'b0;
    end else if (upd) begin
      if (mHit(pce)) begin
        if (tk) begin
          mCtr[i] = (mCtr[i] < CTRMAX) ? mCtr[i] + 1 : CTRMAX;
          mTarget[i] = tgt;
        end else begin
          mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
        end
      end else if (tk) begin
        mValid[i]  = 1'b1;
        mTag[i]    = tagOf(pce);
        mTarget[i] = tgt;
        mCtr[i]    = (CTRMAX + 1) / 2;
      end
    end
    if (upd && mBranch < SATMAX) mBranch++;
    if (expMis && mMiss < SATMAX) mMiss++;
    #1;
    checkOutput("branch_count", {28'd0, BranchCount}, mBranch);
    checkOutput("mispredict_count", {28'd0, MispredictCount}, mMiss);
  endtask

  task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    applyStimulus(1'b1, pc, tk, tgt, mPredTaken(pc), mPredPc(pc), 1'b0, pc);
  endtask

  task automatic idle(input logic [31:0] pcf);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, pcf);
  endtask

  // Reset pulse placed between clock edges so nothing but the async path can clear state.
  task automatic asyncReset();
    #2;
    reset = 1'b0;
    #1;
    mReset();
    checkOutput("rst_pred_taken", {31'd0, PredTakenF}, 32'd0);
    checkOutput("rst_pred_pc", PredPCF, PCF + 32'd4);
    checkOutput("rst_branch_count", {28'd0, BranchCount}, 32'd0);
    checkOutput("rst_mispredict_count", {28'd0, MispredictCount}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] pce;
    logic [31:0] tgt;
    logic [31:0] ppc;
    bit          tk;
    bit          pt;

    reset = 1'b0; UpdateE = 1'b0; PCE = '0; TakenE = 1'b0; TargetE = '0;
    PredTakenE = 1'b0; PredPCE = '0; Invalidate = 1'b0; PCF = 32'h100;
    mReset();
    #2;
    checkOutput("cold_pred_taken", {31'd0, PredTakenF}, 32'd0);
    checkOutput("cold_pred_pc", PredPCF, 32'h104);
    checkOutput("cold_branch_count", {28'd0, BranchCount}, 32'd0);
    PCF = 32'hFFFF_FFFC;
    #1;
    checkOutput("cold_wrap_pc", PredPCF, 32'h0);
    #5;
    reset = 1'b1;

    applyStimulus(1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h44, 1'b0, 32'h100);
    idle(32'h40);
    checkOutput("first_pred_taken", {31'd0, PredTakenF}, 32'd1);
    checkOutput("first_pred_pc", PredPCF, 32'h10);
    checkOutput("first_branch_count", {28'd0, BranchCount}, 32'd1);
    checkOutput("first_mispredict_count", {28'd0, MispredictCount}, 32'd1);

    train(32'h40, 1'b0, 32'h10);
    idle(32'h40);
    checkOutput("hyst_nt_pred", {31'd0, PredTakenF}, 32'd0);
    train(32'h40, 1'b1, 32'h10);
    train(32'h40, 1'b1, 32'h10);
    train(32'h40, 1'b0, 32'h10);
    idle(32'h40);
    checkOutput("hyst_strong_pred", {31'd0, PredTakenF}, 32'd1);
    checkOutput("hyst_strong_pc", PredPCF, 32'h10);

    idle(32'h80);
    checkOutput("alias_miss_pc", PredPCF, 32'h84);
    train(32'h80, 1'b1, 32'h200);
    idle(32'h80);
    checkOutput("alias_new_pc", PredPCF, 32'h200);
    PCF = 32'h40;
    #1;
    checkOutput("alias_evicted_pc", PredPCF, 32'h44);

    applyStimulus(1'b1, 32'h60, 1'b1, 32'h300, 1'b0, 32'h64, 1'b1, 32'h80);
    idle(32'h60);
    checkOutput("inval_pred_pc", PredPCF, 32'h64);
    PCF = 32'h80;
    #1;
    checkOutput("inval_other_pc", PredPCF, 32'h84);

    asyncReset();
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h500 + 32'(k * 4), 1'b0, 32'h104, 1'b0, 32'h100);
    checkOutput("sat_branch_count", {28'd0, BranchCount}, 32'd15);
    checkOutput("sat_mispredict_count", {28'd0, MispredictCount}, 32'd15);
    checkOutput("sat_pred_taken", {31'd0, PredTakenF}, 32'd1);
    asyncReset();

    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 24) asyncReset();
      pce = randPc();
      tk  = ($urandom_range(0, 2) != 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if (mHit(pce) && $urandom_range(0, 1) == 1) tgt = mTarget[idxOf(pce)];
      pt  = mPredTaken(pce);
      ppc = mPredPc(pce);
      if ($urandom_range(0, 5) == 0) pt = ~pt;
      if ($urandom_range(0, 7) == 0) ppc = $urandom & 32'hFFFF_FFFC;
      applyStimulus(($urandom_range(0, 3) != 0), pce, tk, tgt, pt, ppc,
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 2) == 0) ? pce : randPc());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rv32_branch_predictor.md
# rv32_branch_predictor

Parametrised dynamic branch predictor for the 5-stage RV32 pipeline. The current pipeline always fetches PC+4 and flushes D/E on every taken branch or jump. This block replaces that with a direct-mapped branch target buffer (BTB) holding saturating direction counters. Fetch gets a combinational next-PC prediction; Execute trains the tables and receives a mispredict/redirect signal, so the hazard unit flushes only on a wrong prediction.

## Interface
Parameters:
- word_width, 32, datapath/PC width
- entries, 16, BTB entries; power of two, ≥2; idx_bits = log2(entries)
- counter_bits, 2, direction counter width, ≥1
- stat_width, 32, width of the statistics counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- PCF  in  word_width  fetch-stage PC
- PredTakenF  out  1  lookup hit and counter MSB = 1
- PredPCF  out  word_width  predicted next fetch PC: stored target if PredTakenF, else PCF+4
- UpdateE  in  1  valid, unflushed branch/jump in Execute this cycle
- PCE  in  word_width  PC of the Execute instruction
- TakenE  in  1  resolved direction (jumps always 1)
- TargetE  in  word_width  resolved target
- PredTakenE, PredPCE  in  1, word_width  prediction carried down the pipe with the instruction
- MispredictE  out  1  prediction was wrong; hazard unit flushes D/E
- RedirectPCE  out  word_width  correct next PC: TargetE if TakenE, else PCE+4
- Invalidate  in  1  synchronous clear of all valid bits (fence.i)
- BranchCount, MispredictCount  out  stat_width  saturating counts of updates and mispredicts

## Operation
- Index = PC[idx_bits+1:2]. Tag = PC[word_width-1:idx_bits+2]. Each entry holds valid, tag, target and counter.
- Lookup (combinational): hit = valid[idx] && tag[idx] == tag(PCF).
  - PredTakenF = hit && counter[idx][MSB].
  - PredPCF = PredTakenF ? target[idx] : PCF+4, with mod 2^word_width wrap.
- MispredictE = UpdateE && ((TakenE != PredTakenE) || (TakenE && PredPCE != TargetE)). It is 0 when UpdateE = 0.
- RedirectPCE is always driven, independent of UpdateE.
- Update on a clock edge with UpdateE = 1, using the index and tag of PCE:
  - Hit: counter saturating +1 if TakenE, saturating −1 if not. If TakenE, target ← TargetE.
  - Miss and TakenE: allocate and overwrite. Set valid = 1, tag and target written, counter = weakly taken (MSB 1, rest 0).
  - Miss and not TakenE: no allocation, no change.
- Invalidate on a clock edge clears every valid bit. It has priority over a same-cycle update, so nothing is allocated that cycle. Counters and targets are untouched. Statistics still count that cycle's update.
- Statistics: BranchCount +1 per UpdateE cycle. MispredictCount +1 per MispredictE cycle. Both saturate at all-ones.
- Reset (asynchronous, any time, including mid-update):
  - all valid bits 0;
  - all counters weakly not-taken (MSB 0, rest 1; 0 when counter_bits = 1);
  - targets and tags 0;
  - both statistics counters 0.
- Outputs while reset is asserted: PredTakenF 0, PredPCF = PCF+4, BranchCount 0, MispredictCount 0. MispredictE and RedirectPCE follow their inputs combinationally.

## Timing
- Lookup has zero latency: PredTakenF and PredPCF are combinational from PCF and current state. No stall input is needed; the fetch stage holds PCF.
- An update is visible to lookups from the cycle after its edge. A same-cycle lookup and update to the same index returns the pre-update entry; there is no bypass.
- MispredictE and RedirectPCE are combinational in the Execute cycle. The hazard unit uses MispredictE in place of the old PCSrcE for FlushD/FlushE.
- Statistics counters update on the same edge as the table.
- Only one update per cycle; there is no hazard between update and Invalidate beyond the priority rule above.
- Reset release is asynchronous to clk; the first update edge is the first rising clk with reset = 1.

## Test plan
- Cold start: after reset, PCF = 0x100 → PredTakenF 0, PredPCF 0x104. PCF = 0xFFFFFFFC → PredPCF 0x00000000.
- First taken branch: UpdateE, PCE 0x40, TakenE 1, TargetE 0x10, PredTakenE 0, PredPCE 0x44.
  - Same cycle: MispredictE 1, RedirectPCE 0x10.
  - Next cycle, PCF 0x40: PredTakenF 1, PredPCF 0x10. BranchCount 1, MispredictCount 1.
- Hysteresis (counter_bits 2), PC 0x40 after allocation:
  - not-taken → predict not-taken;
  - taken, taken → counter 11;
  - not-taken → still predicts taken, PredPCF 0x10.
- Aliasing (entries 16): after 0x40 is allocated, PCF 0x80 → miss, PredPCF 0x84.
  - Taken update at 0x80 → target 0x200.
  - Afterwards 0x80 predicts 0x200 and 0x40 misses (PredPCF 0x44).
- Invalidate together with a taken update at 0x60 → the next cycle all lookups miss, including 0x60. BranchCount still increments.
- Saturation and async reset (stat_width 4): 20 mispredicting updates → both counts hold 15. Assert reset mid-cycle with no clock edge → counts 0 and PredTakenF 0 immediately.
